mem_port_arb: RTL and testbench

- Sequences and shares the single unified memory port of the multi-cycle CPU between two requesters: the instruction-fetch path (IF state) and the data path (lw/sw MEM state).
- Arbitrates round-robin, registers each transaction and drives a wait-state memory through a req/ready handshake.
- Returns read data with a one-cycle done pulse, and aborts any access that stalls too long, flagging an error.

---
 rtl/mem_port_arb.sv | 154 +++++++++++++++
 tb/tb_mem_port_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one wait-state memory port between instruction fetch
// and data access, with registered handshakes and a stall timeout.
module mem_port_arb #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          tmo_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t        r_state;
  logic          r_last_dm;
  logic [7:0]    r_cnt;
  logic          r_if_gnt;
  logic          r_if_done;
  logic [DW-1:0] r_if_rdata;
  logic          r_dm_gnt;
  logic          r_dm_done;
  logic [DW-1:0] r_dm_rdata;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [3:0]    r_mem_be;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_tmo_err;

  logic          w_pick_if;
  logic          w_pick_dm;
  logic          w_finish;
  logic [DW-1:0] w_ret_data;

  // On a tie the port that was not granted last wins; last resets to DM so fetch wins first.
  always_comb begin
    w_pick_if  = if_req & (~dm_req | r_last_dm);
    w_pick_dm  = dm_req & ~w_pick_if;
    w_finish   = mem_ready | (r_cnt == TMO_C);
    w_ret_data = mem_ready ? mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_dm   <= 1'b1;
      r_cnt       <= '0;
      r_if_gnt    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_gnt    <= 1'b0;
      r_dm_done   <= 1'b0;
      r_dm_rdata  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_if_gnt  <= 1'b0;
      r_dm_gnt  <= 1'b0;
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_if) begin
            r_state    <= BUSY_IF;
            r_last_dm  <= 1'b0;
            r_cnt      <= '0;
            r_if_gnt   <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_be   <= '1;
            r_mem_addr <= if_addr;
          end else if (w_pick_dm) begin
            r_state     <= BUSY_DM;
            r_last_dm   <= 1'b1;
            r_cnt       <= '0;
            r_dm_gnt    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_be    <= dm_we ? dm_be : 4'hF;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
          end
        end
        BUSY_IF, BUSY_DM: begin
          // mem_ready takes priority, so a ready arriving on the timeout cycle completes cleanly.
          if (w_finish) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            if (!mem_ready) begin
              r_tmo_err <= 1'b1;
            end
            if (r_state == BUSY_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_ret_data;
            end else begin
              r_dm_done <= 1'b1;
              if (!r_mem_we) begin
                r_dm_rdata <= w_ret_data;
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_done   = r_dm_done;
  assign dm_rdata  = r_dm_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: stimulus queues expected gnt/done events,
// a negedge monitor pops and checks them against cycle, data and error flag.
module tb_mem_port_arb;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          tmo_err;

  mem_port_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // ev = {if_gnt, dm_gnt, if_done, dm_done}
  typedef struct {
    logic [3:0]  ev;
    int unsigned cyc;
    logic [31:0] rdata;
    logic        tmo;
    string       name;
  } exp_t;

  exp_t q[$];

  localparam logic [3:0] EV_IF_GNT  = 4'b1000;
  localparam logic [3:0] EV_DM_GNT  = 4'b0100;
  localparam logic [3:0] EV_IF_DONE = 4'b0010;
  localparam logic [3:0] EV_DM_DONE = 4'b0001;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input string name, input logic [3:0] ev, input int unsigned c,
                           input logic [31:0] rd, input logic tmo);
    exp_t e;
    e.ev = ev; e.cyc = c; e.rdata = rd; e.tmo = tmo; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [3:0] w;
    exp_t e;
    w = {if_gnt, dm_gnt, if_done, dm_done};
    if (rst === 1'b0 && w != 4'b0000) begin
      if (q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_event got=%b expected=none at cyc %0d", w, cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_event"}, {28'd0, w}, {28'd0, e.ev});
        chk({e.name, "_cycle"}, cyc, e.cyc);
        if (e.ev[1]) begin
          chk({e.name, "_if_rdata"}, if_rdata, e.rdata);
          chk({e.name, "_tmo_err"}, {31'd0, tmo_err}, {31'd0, e.tmo});
        end else if (e.ev[0]) begin
          chk({e.name, "_dm_rdata"}, dm_rdata, e.rdata);
          chk({e.name, "_tmo_err"}, {31'd0, tmo_err}, {31'd0, e.tmo});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    logic [31:0] base;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_gnt_done", {28'd0, if_gnt, dm_gnt, if_done, dm_done}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_tmo_err", {31'd0, tmo_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, ready in the first BUSY cycle
    c = cyc;
    if_req = 1'b1; if_addr = 32'h0000_3000; mem_ready = 1'b1; mem_rdata = 32'h2008_0005;
    expect_ev("fetch_gnt", EV_IF_GNT, c + 1, '0, 1'b0);
    expect_ev("fetch_done", EV_IF_DONE, c + 2, 32'h2008_0005, 1'b0);
    tick();
    if_req = 1'b0;
    chk("fetch_mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);
    chk("fetch_mem_be", {28'd0, mem_be}, 32'hF);
    chk("fetch_mem_addr", mem_addr, 32'h0000_3000);
    tick();
    mem_ready = 1'b0;
    chk("fetch_idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Store with three wait states
    c = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    expect_ev("store_gnt", EV_DM_GNT, c + 1, '0, 1'b0);
    expect_ev("store_done", EV_DM_DONE, c + 5, 32'h0, 1'b0);
    tick();
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    chk("store_mem_we", {31'd0, mem_we}, 32'd1);
    chk("store_mem_be", {28'd0, mem_be}, 32'h3);
    chk("store_mem_addr", mem_addr, 32'h10);
    chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("store_busy_mem_req", {31'd0, mem_req}, 32'd1);
    tick();
    chk("store_busy_mem_be", {28'd0, mem_be}, 32'h3);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("store_if_rdata_kept", if_rdata, 32'h2008_0005);
    chk("store_done_mem_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Continuous contention: IF, DM, IF, DM
    c = cyc;
    base = 32'hC0DE_0000;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b0000;
    if_addr = 32'h100; dm_addr = 32'h200; mem_ready = 1'b1; mem_rdata = base + c;
    expect_ev("rr1_if_gnt", EV_IF_GNT, c + 1, '0, 1'b0);
    expect_ev("rr1_if_done", EV_IF_DONE, c + 2, base + c + 1, 1'b0);
    expect_ev("rr2_dm_gnt", EV_DM_GNT, c + 3, '0, 1'b0);
    expect_ev("rr2_dm_done", EV_DM_DONE, c + 4, base + c + 3, 1'b0);
    expect_ev("rr3_if_gnt", EV_IF_GNT, c + 5, '0, 1'b0);
    expect_ev("rr3_if_done", EV_IF_DONE, c + 6, base + c + 5, 1'b0);
    expect_ev("rr4_dm_gnt", EV_DM_GNT, c + 7, '0, 1'b0);
    expect_ev("rr4_dm_done", EV_DM_DONE, c + 8, base + c + 7, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      mem_rdata = base + cyc;
      if (i == 3) begin
        chk("rr_load_mem_be", {28'd0, mem_be}, 32'hF);
        chk("rr_load_mem_addr", mem_addr, 32'h200);
      end
      if (i == 7) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    mem_ready = 1'b0;
    tick();

    // Ready arrives exactly on the timeout cycle: normal completion
    c = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_rdata = 32'h5555_AAAA;
    expect_ev("bound_gnt", EV_DM_GNT, c + 1, '0, 1'b0);
    expect_ev("bound_done", EV_DM_DONE, c + TMO + 2, 32'h5555_AAAA, 1'b0);
    for (int i = 1; i <= TMO + 2; i++) begin
      tick();
      if (i == 1) dm_req = 1'b0;
      if (i == TMO + 1) mem_ready = 1'b1;
      if (i == TMO + 2) mem_ready = 1'b0;
    end
    chk("bound_tmo_err", {31'd0, tmo_err}, 32'd0);
    tick();

    // Load that never completes: timeout
    c = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48; mem_rdata = 32'hFFFF_FFFF;
    expect_ev("tmo_gnt", EV_DM_GNT, c + 1, '0, 1'b0);
    expect_ev("tmo_done", EV_DM_DONE, c + TMO + 2, 32'h0, 1'b1);
    for (int i = 1; i <= TMO + 2; i++) begin
      tick();
      if (i == 1) dm_req = 1'b0;
    end
    chk("tmo_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); tick();
    chk("tmo_sticky", {31'd0, tmo_err}, 32'd1);

    c = cyc;
    if_req = 1'b1; if_addr = 32'h3004; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    expect_ev("post_tmo_gnt", EV_IF_GNT, c + 1, '0, 1'b0);
    expect_ev("post_tmo_done", EV_IF_DONE, c + 2, 32'h0BAD_F00D, 1'b1);
    tick();
    if_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();

    // Asynchronous reset during BUSY_DM
    c = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    tick();
    chk("rstbusy_pre_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("rstbusy_pre_req", {31'd0, mem_req}, 32'd1);
    dm_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstbusy_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstbusy_gnt_done", {28'd0, if_gnt, dm_gnt, if_done, dm_done}, 32'd0);
    chk("rstbusy_tmo_err", {31'd0, tmo_err}, 32'd0);
    chk("rstbusy_rdata", if_rdata | dm_rdata, 32'd0);
    tick(); tick();
    rst = 1'b0;
    c = cyc;
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h500; dm_addr = 32'h600;
    mem_ready = 1'b1; mem_rdata = 32'h600D_0001;
    expect_ev("rst_tie_if_gnt", EV_IF_GNT, c + 1, '0, 1'b0);
    expect_ev("rst_tie_if_done", EV_IF_DONE, c + 2, 32'h600D_0001, 1'b0);
    tick();
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick(); tick(); tick();

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
